// File: rtl/uart_pkt_led_ctrl.sv
// Framed UART command parser driving NUM_CH LED channels (OFF/ON/BLINK/PULSE).
// Define UART_PKT_CKSUM_EN to add a trailing XOR checksum byte to every frame.
module uart_pkt_led_ctrl #(
  parameter int         NUM_CH       = 4,
  parameter int         TICK_DIV     = 50000,
  parameter int         TIMEOUT_CLKS = 500000,
  parameter logic [7:0] HDR          = 8'hA5
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        uart_data,
  input  logic              uart_done,
  output logic [NUM_CH-1:0] led,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [7:0]        pkt_cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    NUM_CH_B  = 8'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_CH, S_MODE, S_VHI, S_VLO
`ifdef UART_PKT_CKSUM_EN
    , S_CK
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      chSel_q, chSel_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      valHi_q, valHi_d;
  logic            bad_q, bad_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pktOk_q, pktOk_d;
  logic            pktErr_q, pktErr_d;
  logic [7:0]      pktCnt_q, pktCnt_d;
`ifdef UART_PKT_CKSUM_EN
  logic [7:0]      valLo_q, valLo_d;
  logic [7:0]      cksum_q, cksum_d;
`endif

  logic [1:0]      chMode_q [NUM_CH];
  logic [1:0]      chMode_d [NUM_CH];
  logic [15:0]     chVal_q  [NUM_CH];
  logic [15:0]     chVal_d  [NUM_CH];
  logic [15:0]     msCnt_q  [NUM_CH];
  logic [15:0]     msCnt_d  [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;

  logic            tick;
  logic            commit;
  logic [15:0]     commitVal;

  // A zero period behaves as one tick so BLINK/PULSE always make progress.
  function automatic logic limReached(input logic [15:0] cnt, input logic [15:0] val);
    logic [15:0] lim;
    lim = (val == 16'd0) ? 16'd1 : val;
    return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
  endfunction

  assign tick    = (presc_q == PRESC_MAX);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    chSel_d   = chSel_q;
    mode_d    = mode_q;
    valHi_d   = valHi_q;
    bad_d     = bad_q;
    gap_d     = gap_q;
    pktErr_d  = 1'b0;
    commit    = 1'b0;
`ifdef UART_PKT_CKSUM_EN
    valLo_d   = valLo_q;
    cksum_d   = cksum_q;
    commitVal = {valHi_q, valLo_q};
`else
    commitVal = {valHi_q, uart_data};
`endif

    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (state_q == S_IDLE || uart_done) begin
      gap_d = '0;
    end else if (gap_q == GAP_MAX) begin
      gap_d    = '0;
      state_d  = S_IDLE;
      pktErr_d = 1'b1;
    end else begin
      gap_d = gap_q + GW'(1);
    end

    if (uart_done) begin
      case (state_q)
        S_IDLE: begin
          if (uart_data == HDR) begin
            state_d = S_CH;
            bad_d   = 1'b0;
`ifdef UART_PKT_CKSUM_EN
            cksum_d = 8'h00;
`endif
          end
        end
        S_CH: begin
          chSel_d = uart_data;
          bad_d   = (uart_data >= NUM_CH_B);
          state_d = S_MODE;
`ifdef UART_PKT_CKSUM_EN
          cksum_d = cksum_q ^ uart_data;
`endif
        end
        S_MODE: begin
          mode_d  = uart_data[1:0];
          bad_d   = bad_q | (uart_data > 8'd3);
          state_d = S_VHI;
`ifdef UART_PKT_CKSUM_EN
          cksum_d = cksum_q ^ uart_data;
`endif
        end
        S_VHI: begin
          valHi_d = uart_data;
          state_d = S_VLO;
`ifdef UART_PKT_CKSUM_EN
          cksum_d = cksum_q ^ uart_data;
`endif
        end
`ifdef UART_PKT_CKSUM_EN
        S_VLO: begin
          valLo_d = uart_data;
          cksum_d = cksum_q ^ uart_data;
          state_d = S_CK;
        end
        S_CK: begin
          state_d = S_IDLE;
          if (bad_q || (uart_data != cksum_q)) pktErr_d = 1'b1;
          else                                 commit   = 1'b1;
        end
`else
        S_VLO: begin
          state_d = S_IDLE;
          if (bad_q) pktErr_d = 1'b1;
          else       commit   = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pktOk_d  = commit;
  assign pktCnt_d = pktCnt_q + {7'd0, commit};

  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NUM_CH; i++) begin
      chMode_d[i] = chMode_q[i];
      chVal_d[i]  = chVal_q[i];
      msCnt_d[i]  = msCnt_q[i];
      if (commit && (chSel_q == 8'(i))) begin
        chMode_d[i] = mode_q;
        chVal_d[i]  = commitVal;
        msCnt_d[i]  = '0;
        led_d[i]    = (mode_q != 2'd0);
      end else if (tick && chMode_q[i][1]) begin
        if (limReached(msCnt_q[i], chVal_q[i])) begin
          msCnt_d[i] = '0;
          if (chMode_q[i][0]) begin
            chMode_d[i] = 2'd0;
            led_d[i]    = 1'b0;
          end else begin
            led_d[i] = ~led_q[i];
          end
        end else begin
          msCnt_d[i] = msCnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      chSel_q  <= '0;
      mode_q   <= '0;
      valHi_q  <= '0;
      bad_q    <= 1'b0;
      gap_q    <= '0;
      presc_q  <= '0;
      pktOk_q  <= 1'b0;
      pktErr_q <= 1'b0;
      pktCnt_q <= '0;
`ifdef UART_PKT_CKSUM_EN
      valLo_q  <= '0;
      cksum_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      chSel_q  <= chSel_d;
      mode_q   <= mode_d;
      valHi_q  <= valHi_d;
      bad_q    <= bad_d;
      gap_q    <= gap_d;
      presc_q  <= presc_d;
      pktOk_q  <= pktOk_d;
      pktErr_q <= pktErr_d;
      pktCnt_q <= pktCnt_d;
`ifdef UART_PKT_CKSUM_EN
      valLo_q  <= valLo_d;
      cksum_q  <= cksum_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      led_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        chMode_q[i] <= '0;
        chVal_q[i]  <= '0;
        msCnt_q[i]  <= '0;
      end
    end else begin
      led_q <= led_d;
      for (int i = 0; i < NUM_CH; i++) begin
        chMode_q[i] <= chMode_d[i];
        chVal_q[i]  <= chVal_d[i];
        msCnt_q[i]  <= msCnt_d[i];
      end
    end
  end

  assign led     = led_q;
  assign pkt_ok  = pktOk_q;
  assign pkt_err = pktErr_q;
  assign pkt_cnt = pktCnt_q;

endmodule

// File: tb/tb_uart_pkt_led_ctrl.sv
// Directed bench for uart_pkt_led_ctrl with a fast tick (TICK_DIV=4) and short timeout (20 clocks).
module tb_uart_pkt_led_ctrl;

  localparam int NUM_CH       = 4;
  localparam int TICK_DIV     = 4;
  localparam int TIMEOUT_CLKS = 20;
  localparam logic [7:0] HDR  = 8'hA5;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        uart_done = 1'b0;
  logic [3:0]  led;
  logic        pkt_ok;
  logic        pkt_err;
  logic [7:0]  pkt_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  expCnt;

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  mode;
    logic [15:0] val;
    logic        expOk;
    logic        expErr;
    logic [3:0]  expLed;
  } vec_t;

  vec_t vecs [10];

  uart_pkt_led_ctrl #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .TIMEOUT_CLKS(TIMEOUT_CLKS), .HDR(HDR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_data(uart_data), .uart_done(uart_done),
    .led(led), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .pkt_cnt(pkt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled (plus one idle cycle if asked).
  task automatic sendByte(input logic [7:0] b, input bit gapAfter);
    uart_data = b;
    uart_done = 1'b1;
    @(negedge sys_clk);
    uart_done = 1'b0;
    if (gapAfter) @(negedge sys_clk);
  endtask

  task automatic applyStimulus(input logic [7:0] ch, input logic [7:0] mode,
                               input logic [15:0] val, input bit badCk);
    logic [7:0] ck;
    ck = ch ^ mode ^ val[15:8] ^ val[7:0] ^ {7'd0, badCk};
    sendByte(HDR, 1'b1);
    sendByte(ch, 1'b1);
    sendByte(mode, 1'b1);
    sendByte(val[15:8], 1'b1);
`ifdef UART_PKT_CKSUM_EN
    sendByte(val[7:0], 1'b1);
    sendByte(ck, 1'b0);
`else
    sendByte(val[7:0], 1'b0);
`endif
  endtask

  task automatic measureLevel(input int idx, input logic level, input int limit, output int cycles);
    cycles = 0;
    while (led[idx] === level && cycles < limit) begin
      @(negedge sys_clk);
      cycles++;
    end
  endtask

  initial begin
    int  c;
    int  n;
    bit  errSeen;

    vecs[0] = '{8'h01, 8'h01, 16'h0005, 1'b1, 1'b0, 4'b0010};
    vecs[1] = '{8'h07, 8'h01, 16'h0005, 1'b0, 1'b1, 4'b0010};
    vecs[2] = '{8'h00, 8'h04, 16'h0001, 1'b0, 1'b1, 4'b0010};
    vecs[3] = '{8'h03, 8'h01, 16'h0000, 1'b1, 1'b0, 4'b1010};
    vecs[4] = '{8'h01, 8'h00, 16'h1234, 1'b1, 1'b0, 4'b1000};
    vecs[5] = '{8'h00, 8'h01, 16'hFFFF, 1'b1, 1'b0, 4'b1001};
    vecs[6] = '{8'h04, 8'h00, 16'h0000, 1'b0, 1'b1, 4'b1001};
    vecs[7] = '{8'h03, 8'hFF, 16'h0000, 1'b0, 1'b1, 4'b1001};
    vecs[8] = '{8'h03, 8'h00, 16'h0007, 1'b1, 1'b0, 4'b0001};
    vecs[9] = '{8'h00, 8'h00, 16'h0000, 1'b1, 1'b0, 4'b0000};

    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_led", led, 4'b0000);
    checkOutput("rst_pulses", {pkt_ok, pkt_err}, 2'b00);
    checkOutput("rst_cnt", pkt_cnt, 8'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    expCnt = 8'd0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].mode, vecs[i].val, 1'b0);
      if (vecs[i].expOk) expCnt = expCnt + 8'd1;
      checkOutput($sformatf("vec%0d_ok", i), pkt_ok, vecs[i].expOk);
      checkOutput($sformatf("vec%0d_err", i), pkt_err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d_led", i), led, vecs[i].expLed);
      checkOutput($sformatf("vec%0d_cnt", i), pkt_cnt, expCnt);
      @(negedge sys_clk);
      checkOutput($sformatf("vec%0d_pulse_width", i), {pkt_ok, pkt_err}, 2'b00);
    end

    // BLINK VAL=3: first high phase depends on prescaler phase, then strict 12-clock halves.
    applyStimulus(8'h00, 8'h02, 16'h0003, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("blink_commit_ok", pkt_ok, 1'b1);
    checkOutput("blink_commit_led", led, 4'b0001);
    measureLevel(0, 1'b1, 40, c);
    checkOutput("blink_first_high_range", (c >= 9 && c <= 12), 1'b1);
    measureLevel(0, 1'b0, 40, c);
    checkOutput("blink_low_len", c, 12);
    measureLevel(0, 1'b1, 40, c);
    checkOutput("blink_high_len", c, 12);

    applyStimulus(8'h00, 8'h02, 16'h0003, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("recommit_led", led, 4'b0001);
    measureLevel(0, 1'b1, 40, c);
    checkOutput("recommit_high_range", (c >= 9 && c <= 12), 1'b1);
    applyStimulus(8'h00, 8'h00, 16'h0000, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("blink_off_led", led, 4'b0000);

    applyStimulus(8'h02, 8'h03, 16'h0002, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("pulse2_commit_led", led, 4'b0100);
    measureLevel(2, 1'b1, 40, c);
    checkOutput("pulse2_high_range", (c >= 5 && c <= 8), 1'b1);
    repeat (20) @(negedge sys_clk);
    checkOutput("pulse2_stays_off", led, 4'b0000);

    applyStimulus(8'h01, 8'h03, 16'h0000, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("pulse0_commit_led", led, 4'b0010);
    measureLevel(1, 1'b1, 40, c);
    checkOutput("pulse0_high_range", (c >= 1 && c <= 4), 1'b1);
    checkOutput("pulse_cnt", pkt_cnt, expCnt);

    sendByte(HDR, 1'b1);
    sendByte(8'h01, 1'b0);
    n = 0;
    while (pkt_err !== 1'b1 && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("timeout_clock", n, 20);
    checkOutput("timeout_no_ok", pkt_ok, 1'b0);
    repeat (5) @(negedge sys_clk);
    applyStimulus(8'h01, 8'h01, 16'h0000, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("after_timeout_ok", pkt_ok, 1'b1);
    checkOutput("after_timeout_led", led, 4'b0010);

    // MODE byte lands exactly on the expiry cycle and must be consumed.
    errSeen = 1'b0;
    sendByte(HDR, 1'b1);
    sendByte(8'h03, 1'b0);
    repeat (19) begin
      @(negedge sys_clk);
      errSeen = errSeen | pkt_err;
    end
    sendByte(8'h01, 1'b0);
    errSeen = errSeen | pkt_err;
    @(negedge sys_clk);
    errSeen = errSeen | pkt_err;
    sendByte(8'h00, 1'b1);
`ifdef UART_PKT_CKSUM_EN
    sendByte(8'h00, 1'b1);
    sendByte(8'h02, 1'b0);
`else
    sendByte(8'h00, 1'b0);
`endif
    expCnt = expCnt + 8'd1;
    checkOutput("tie_no_err", errSeen, 1'b0);
    checkOutput("tie_ok", pkt_ok, 1'b1);
    checkOutput("tie_led", led, 4'b1010);

`ifdef UART_PKT_CKSUM_EN
    applyStimulus(8'h00, 8'h01, 16'h0012, 1'b1);
    checkOutput("badck_err", pkt_err, 1'b1);
    checkOutput("badck_led", led, 4'b1010);
    checkOutput("badck_cnt", pkt_cnt, expCnt);
`endif

    while (expCnt != 8'd255) begin
      applyStimulus(8'h00, 8'h00, 16'h0000, 1'b0);
      expCnt = expCnt + 8'd1;
    end
    checkOutput("cnt_at_255", pkt_cnt, 8'd255);
    applyStimulus(8'h00, 8'h00, 16'h0000, 1'b0);
    expCnt = expCnt + 8'd1;
    checkOutput("cnt_wrap", pkt_cnt, 8'd0);
    checkOutput("cnt_wrap_ok", pkt_ok, 1'b1);

    sendByte(HDR, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h01, 1'b0);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    sendByte(8'h00, 1'b0);
    checkOutput("midrst_pulse_a", {pkt_ok, pkt_err}, 2'b00);
    sendByte(8'h05, 1'b0);
    checkOutput("midrst_pulse_b", {pkt_ok, pkt_err}, 2'b00);
    checkOutput("midrst_led", led, 4'b0000);
    checkOutput("midrst_cnt", pkt_cnt, 8'd0);
    @(negedge sys_clk);
    applyStimulus(8'h02, 8'h01, 16'h0000, 1'b0);
    checkOutput("midrst_next_ok", pkt_ok, 1'b1);
    checkOutput("midrst_next_led", led, 4'b0100);
    checkOutput("midrst_next_cnt", pkt_cnt, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_pkt_led_ctrl.md
# uart_pkt_led_ctrl

Parametrised successor to the single-LED UART demo top: consumes the byte stream from the UART receiver (`uart_data`/`uart_done`) and parses framed commands addressed to one of `NUM_CH` LED channels. Each channel is OFF, ON, BLINK or one-shot PULSE, with a 16-bit millisecond value. Frames carry range checks, an optional XOR checksum and an inter-byte timeout. Sits between the UART RX block and the board LED pins in the 50 MHz domain.

## Interface
- `NUM_CH`, 4, number of LED channels (1..16)
- `TICK_DIV`, 50000, clocks per millisecond tick (50 MHz -> 1 ms)
- `TIMEOUT_CLKS`, 500000, max clocks between bytes inside a frame (10 ms)
- `HDR`, 8'hA5, frame header byte

- `sys_clk`  in  1  system clock; single clock domain
- `sys_rst_n`  in  1  reset, synchronous, active-low
- `uart_data`  in  8  received byte, valid when `uart_done`=1
- `uart_done`  in  1  one-cycle byte-valid strobe
- `led`  out  NUM_CH  per-channel LED drive, active high
- `pkt_ok`  out  1  one-cycle pulse, good frame committed
- `pkt_err`  out  1  one-cycle pulse, frame rejected or timed out
- `pkt_cnt`  out  8  count of good frames, wraps 255->0

## Operation
- Frame: `HDR`, CH, MODE, VAL[15:8], VAL[7:0], [CK]. CK = XOR of CH..VAL[7:0].
- FSM states: IDLE -> CH -> MODE -> VHI -> VLO -> (CK) -> IDLE. Each advance happens on `uart_done`.
- IDLE: non-`HDR` bytes are ignored silently. A `HDR` byte mid-frame is treated as data; there is no resync.
- Bad flag is latched if CH >= `NUM_CH` or MODE > 3. The frame is still consumed to its end, then `pkt_err` fires and no state changes.
- Commit on a good last byte: the channel's mode/value registers load, its ms counter clears, `pkt_ok` pulses and `pkt_cnt` increments.
- Modes:
  - 0 OFF: led=0.
  - 1 ON: led=1.
  - 2 BLINK: led starts at 1 on commit and toggles every max(VAL,1) ms ticks.
  - 3 PULSE: led=1 for max(VAL,1) ms ticks, then the channel's mode self-clears to 0.
- Prescaler is free-running 0..`TICK_DIV`-1. The tick is one cycle at terminal count and is shared by all channels.
- Timeout: outside IDLE, the byte-gap counter resets on each `uart_done`. On reaching `TIMEOUT_CLKS`-1: FSM -> IDLE, `pkt_err` pulses, and the partial frame is discarded.

## Timing
- Reset (sync, active-low): FSM IDLE; all mode/value/ms counters 0; `led`=0; `pkt_ok`=`pkt_err`=0; `pkt_cnt`=0; prescaler 0.
- `pkt_ok`/`pkt_err` assert exactly 1 cycle after the `uart_done` of the last frame byte.
- Register update and `led` change are visible in that same cycle.
- Channel ms counters advance only on ticks.
  - Toggle or PULSE end occurs on the cycle after the tick on which the count reaches VAL.
  - The count then restarts at 0.
- Re-commit to an active channel restarts it immediately; the old phase is lost.
- Timeout expiry in the same cycle as `uart_done`: the byte wins, is processed, and the gap counter resets. No error.
- `pkt_cnt` 255 + good frame -> 0.
- `pkt_ok` and `pkt_err` are never high together.
- Reset mid-frame drops the frame with no pulse.

## Configuration
- `UART_PKT_CKSUM_EN`:
  - Defined: 6-byte frames. State CK exists, and a mismatch gives `pkt_err` with no commit.
  - Undefined: 5-byte frames. VLO is the last byte, and the CK state and XOR logic are removed.

## Test plan
- Good ON: A5,01,01,00,05,05 -> one cycle after last `uart_done`, `led[1]`=1, `pkt_ok` pulse, `pkt_cnt`=1.
- BLINK, `TICK_DIV`=4: A5,00,02,00,03,01 -> `led[0]`=1 on commit, toggling every 12 clocks, with period 24.
- PULSE VAL=2, `TICK_DIV`=4: A5,02,03,00,02,03 -> `led[2]` high ~8 clocks, then 0, and the channel reads mode 0.
- Errors:
  - CH=07 with `NUM_CH`=4 -> `pkt_err`, no LED change.
  - MODE=04 -> `pkt_err`.
  - Wrong CK (macro on) -> `pkt_err`, `pkt_cnt` unchanged.
- Timeout, `TIMEOUT_CLKS`=20: A5,01 then 25 idle clocks -> `pkt_err` at clock 20. A following full good frame is accepted.
- Timeout tie: `uart_done` exactly on the expiry cycle -> no `pkt_err`, byte consumed. Also 256 good frames -> `pkt_cnt` wraps to 0.
